updown_counter_param: RTL and testbench

//  Parametrised synchronous up/down counter with built-in prescaler, sync load/clear,

---
 rtl/updown_counter_param_pkg.sv | 12 +
 rtl/tick_gen.sv | 38 +++
 rtl/updown_counter_param.sv | 98 +++++++++
 tb/tb_updown_counter_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_param_pkg.sv
// Shared constants and helpers for the parametrised up/down counter and its prescaler.
package updown_counter_param_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Bits needed to hold 0..val-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned val);
    return (val <= 2) ? 1 : $clog2(val);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle step enable once every DIV enabled clock cycles.
module tick_gen
  import updown_counter_param_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned     PreW   = clog2_min1(DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;

  assign step = en && (pre_q == PreMax);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = step ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter with prescaler, sync clear/load, programmable modulus and
// wrap-or-saturate at the range ends. All outputs are registered.
module updown_counter_param
  import updown_counter_param_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned DIV      = 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("updown_counter_param: MODULUS must be 2..2**WIDTH");
  end
  if (DIV < 1) begin : g_bad_div
    $error("updown_counter_param: DIV must be >= 1");
  end

  localparam logic [WIDTH-1:0] QMax = WIDTH'(MODULUS - 1);

  logic             step;
  logic             at_end;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .step (step)
  );

  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    ovf_d  = ovf_q;
    // Range end in the current direction of travel.
    at_end = up ? (q_q == QMax) : (q_q == '0);
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = (load_val > QMax) ? QMax : load_val;
    end else if (step) begin
      tick_d = 1'b1;
      if (at_end) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (SATURATE != MODE_SAT) begin
          q_d = up ? '0 : QMax;
        end
      end else begin
        q_d = up ? q_q + 1'b1 : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: four counter configurations share one input bus; directed
// sequences, a vector table and a randomised run against a behavioural model.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, clr, load;
  logic [3:0] load_val;

  logic [3:0] q_o [4];
  logic [3:0] tick_v, tc_v, ovf_v;

  int n_pass  = 0;
  int n_total = 0;

  // Configurations: 0 = M16/D1/wrap, 1 = M10/D4/wrap, 2 = M10/D1/sat, 3 = M10/D3/wrap
  int cfg_m [4] = '{16, 10, 10, 10};
  int cfg_d [4] = '{1, 4, 1, 3};
  int cfg_s [4] = '{0, 0, 1, 0};

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MODULUS(16), .DIV(1), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .q(q_o[0]), .tick(tick_v[0]), .tc(tc_v[0]), .ovf(ovf_v[0])
  );
  updown_counter_param #(.WIDTH(4), .MODULUS(10), .DIV(4), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .q(q_o[1]), .tick(tick_v[1]), .tc(tc_v[1]), .ovf(ovf_v[1])
  );
  updown_counter_param #(.WIDTH(4), .MODULUS(10), .DIV(1), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .q(q_o[2]), .tick(tick_v[2]), .tc(tc_v[2]), .ovf(ovf_v[2])
  );
  updown_counter_param #(.WIDTH(4), .MODULUS(10), .DIV(3), .SATURATE(0)) u_d (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .q(q_o[3]), .tick(tick_v[3]), .tc(tc_v[3]), .ovf(ovf_v[3])
  );

  // Behavioural reference, modulo arithmetic on plain integers.
  int mq [4], mpre [4], mtick [4], mtc [4], movf [4];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        mq[k] <= 0; mpre[k] <= 0; mtick[k] <= 0; mtc[k] <= 0; movf[k] <= 0;
      end else begin
        mtick[k] <= 0;
        mtc[k]   <= 0;
        if (clr) begin
          mq[k] <= 0; mpre[k] <= 0; movf[k] <= 0;
        end else begin
          if (en) mpre[k] <= (mpre[k] == cfg_d[k] - 1) ? 0 : mpre[k] + 1;
          if (load) begin
            mq[k] <= (int'(load_val) >= cfg_m[k]) ? cfg_m[k] - 1 : int'(load_val);
          end else if (en && mpre[k] == cfg_d[k] - 1) begin
            mtick[k] <= 1;
            if (up ? (mq[k] == cfg_m[k] - 1) : (mq[k] == 0)) begin
              mtc[k]  <= 1;
              movf[k] <= 1;
              if (cfg_s[k] == 0) mq[k] <= up ? 0 : cfg_m[k] - 1;
            end else begin
              mq[k] <= up ? (mq[k] + 1) % cfg_m[k] : (mq[k] + cfg_m[k] - 1) % cfg_m[k];
            end
          end
        end
      end
    end
  end

  function automatic int obs(int k);
    return {25'd0, q_o[k], tick_v[k], tc_v[k], ovf_v[k]};
  endfunction

  function automatic int model_obs(int k);
    return (mq[k] << 3) | (mtick[k] << 2) | (mtc[k] << 1) | movf[k];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       en, up, clr, load;
    logic [3:0] lv;
    int         eq;
    logic       et, etc, eo;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Table for configuration 2 (M10, D1, saturate).
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd8,  8, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  9, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  9, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  9, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 9, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  3, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  2, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  2, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd7,  7, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  6, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) check($sformatf("reset_dut%0d", k), obs(k), 0);

    // Full up-count with wrap on configuration 0.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step_clk();
      check($sformatf("t1_q_%0d", i), int'(q_o[0]), i % 16);
      check($sformatf("t1_tick_%0d", i), int'(tick_v[0]), 1);
      check($sformatf("t1_tc_%0d", i), int'(tc_v[0]), int'(i == 16));
      check($sformatf("t1_ovf_%0d", i), int'(ovf_v[0]), int'(i >= 16));
    end

    // Down-count through the divide-by-4 prescaler on configuration 1.
    clr = 1'b1; en = 1'b0;
    step_clk();
    clr = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step_clk();
      check($sformatf("t2_q_%0d", i), int'(q_o[1]), (i < 4) ? 0 : ((i < 8) ? 9 : 8));
      check($sformatf("t2_tick_%0d", i), int'(tick_v[1]), int'(i == 4 || i == 8));
      check($sformatf("t2_tc_%0d", i), int'(tc_v[1]), int'(i == 4));
    end
    repeat (2) step_clk();
    en = 1'b0;
    repeat (5) step_clk();
    check("t2_frozen_q", int'(q_o[1]), 8);
    check("t2_frozen_tick", int'(tick_v[1]), 0);
    en = 1'b1;
    step_clk();
    check("t2_resume1_q", int'(q_o[1]), 8);
    check("t2_resume1_tick", int'(tick_v[1]), 0);
    step_clk();
    check("t2_resume2_q", int'(q_o[1]), 7);
    check("t2_resume2_tick", int'(tick_v[1]), 1);
    check("t2_ovf", int'(ovf_v[1]), 1);

    // Load clamp, saturation, and load/clear/step priority on configuration 2.
    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; up = vecs[i].up; clr = vecs[i].clr;
      load = vecs[i].load; load_val = vecs[i].lv;
      step_clk();
      check($sformatf("vec%0d_q", i), int'(q_o[2]), vecs[i].eq);
      check($sformatf("vec%0d_tick", i), int'(tick_v[2]), int'(vecs[i].et));
      check($sformatf("vec%0d_tc", i), int'(tc_v[2]), int'(vecs[i].etc));
      check($sformatf("vec%0d_ovf", i), int'(ovf_v[2]), int'(vecs[i].eo));
    end

    // Asynchronous reset between edges with a partial prescaler count (configuration 3).
    en = 1'b0; up = 1'b0; clr = 1'b1; load = 1'b0; load_val = 4'd0;
    step_clk();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    repeat (5) step_clk();
    check("t5_before_q", int'(q_o[3]), 1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("t5_async_dut%0d", k), obs(k), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_e1_q", int'(q_o[3]), 0);
    check("t5_e1_tick", int'(tick_v[3]), 0);
    step_clk();
    check("t5_e2_tick", int'(tick_v[3]), 0);
    step_clk();
    check("t5_e3_q", int'(q_o[3]), 1);
    check("t5_e3_tick", int'(tick_v[3]), 1);

    // Randomised traffic on all four configurations against the model.
    for (int n = 0; n < 3000; n++) begin
      en       = ($urandom % 4) != 0;
      up       = $urandom % 2;
      load     = ($urandom % 16) == 0;
      clr      = ($urandom % 32) == 0;
      load_val = 4'($urandom % 16);
      step_clk();
      begin
        int act, exp;
        act = 0;
        exp = 0;
        for (int k = 0; k < 4; k++) begin
          act = (act << 8) | obs(k);
          exp = (exp << 8) | model_obs(k);
        end
        check($sformatf("rand_%0d", n), act, exp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
